// File: rtl/pc060ha_pkg.sv
// PC060HA master-side sequencer: shared types and constants.
// Op codes, index map, flag positions and FSM encodings.
package pc060ha_pkg;

  typedef enum logic [1:0] {
    OP_SEND  = 2'd0,
    OP_RECV  = 2'd1,
    OP_SRST  = 2'd2,
    OP_FLAGS = 2'd3
  } op_e;

  localparam logic [3:0] IDX_PAIR0 = 4'd0;
  localparam logic [3:0] IDX_PAIR1 = 4'd2;
  localparam logic [3:0] IDX_CTRL  = 4'd4;

  localparam int F_M2S0 = 0;
  localparam int F_M2S1 = 1;
  localparam int F_S2M0 = 2;
  localparam int F_S2M1 = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_IDX_CTRL,
    S_POLL,
    S_POLL_WAIT,
    S_IDX_DATA,
    S_XFER_LO,
    S_XFER_HI,
    S_CTRL_WR,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_ADDR,
    BC_STRB,
    BC_RCVR
  } bc_e;

  function automatic logic [3:0] pair_idx(
    input logic p
  );
    return p ? IDX_PAIR1 : IDX_PAIR0;
  endfunction

  // SEND waits for its m2s slot to drain, RECV for s2m data
  function automatic logic poll_ok(
    input op_e        op,
    input logic       p,
    input logic [3:0] f
  );
    if (op == OP_SEND)
      return p ? !f[F_M2S1] : !f[F_M2S0];
    return p ? f[F_S2M1] : f[F_S2M0];
  endfunction

endpackage

// File: rtl/pc060ha_master_seq_if.sv
// Host command/response handshake of the PC060HA master sequencer.
// master = host glue logic, slave = sequencer.
interface pc060ha_master_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_pair;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_pair, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pair, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/pc060ha_bus_cycle.sv
// One PC060HA master access: ADDR, STROBE_CYC strobe clocks, RECOVER.
// Pins are registered from the next phase so they never glitch.
module pc060ha_bus_cycle
  import pc060ha_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic       MCLK,
  input  logic       nIC,
  input  logic       start,
  input  logic       is_read,
  input  logic       a0,
  input  logic [3:0] wdata,
  output logic       done,
  output logic [3:0] rdata,
  output logic       nMCS,
  output logic       nMRD,
  output logic       nMWR,
  output logic       MA0,
  output logic [3:0] MD_OUT,
  output logic       MD_OE,
  input  logic [3:0] MD_IN
);

  localparam logic [7:0] SLAST = 8'(STROBE_CYC - 1);

  bc_e        ph;
  bc_e        ph_n;
  logic [7:0] cnt;
  logic       rd_q;
  logic       load;
  logic       rd_n;

  assign done = (ph == BC_RCVR);
  assign load = start && (ph == BC_IDLE || ph == BC_RCVR);
  assign rd_n = load ? is_read : rd_q;

  always_comb begin
    ph_n = ph;
    unique case (ph)
      BC_IDLE: if (start) ph_n = BC_ADDR;
      BC_ADDR: ph_n = BC_STRB;
      BC_STRB: if (cnt == SLAST) ph_n = BC_RCVR;
      BC_RCVR: ph_n = start ? BC_ADDR : BC_IDLE;
      default: ph_n = BC_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge nIC) begin
    if (!nIC) begin
      ph     <= BC_IDLE;
      cnt    <= 8'd0;
      rd_q   <= 1'b0;
      rdata  <= 4'h0;
      nMCS   <= 1'b1;
      nMRD   <= 1'b1;
      nMWR   <= 1'b1;
      MA0    <= 1'b0;
      MD_OUT <= 4'h0;
      MD_OE  <= 1'b0;
    end else begin
      ph  <= ph_n;
      cnt <= (ph == BC_STRB) ? cnt + 8'd1 : 8'd0;
      // MA0 settles in ADDR, ahead of the nMCS fall that latches it
      if (load) begin
        rd_q   <= is_read;
        MA0    <= a0;
        MD_OUT <= wdata;
      end
      MD_OE <= (ph_n != BC_IDLE) && !rd_n;
      nMCS  <= !(ph_n == BC_STRB);
      nMRD  <= !(ph_n == BC_STRB && rd_n);
      nMWR  <= !(ph_n == BC_STRB && !rd_n);
      if (ph == BC_STRB && cnt == SLAST)
        rdata <= MD_IN;
    end
  end

endmodule

// File: rtl/pc060ha_master_seq.sv
// PC060HA master bus initiator: byte commands to nibble bus cycles.
// Handles control-index setup, flag polling and nibble ordering.
module pc060ha_master_seq
  import pc060ha_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int POLL_GAP   = 0,
  parameter int POLL_LIMIT = 0
) (
  input  logic                       MCLK,
  input  logic                       nIC,
  pc060ha_master_seq_if.slave        hst,
  output logic                       nMCS,
  output logic                       nMRD,
  output logic                       nMWR,
  output logic                       MA0,
  output logic [3:0]                 MD_OUT,
  output logic                       MD_OE,
  input  logic [3:0]                 MD_IN
);

  localparam logic [7:0]  GLAST = 8'(POLL_GAP - 1);
  localparam logic [15:0] PLAST = 16'(POLL_LIMIT - 1);

  state_e      st;
  state_e      st_n;
  op_e         op_q;
  logic        pair_q;
  logic [7:0]  dat_q;
  logic [3:0]  lo_q;
  logic [15:0] polls;
  logic [7:0]  gcnt;
  logic        accept;
  logic        limit_hit;
  logic        start;
  logic        is_read;
  logic        a0;
  logic [3:0]  wdata;
  logic        done;
  logic [3:0]  rdata;
  logic [7:0]  rsp_d_n;
  logic        rsp_e_n;

  assign accept    = hst.cmd_valid && hst.cmd_ready;
  assign limit_hit = (POLL_LIMIT != 0) && (polls == PLAST);

  always_comb begin
    st_n    = st;
    start   = 1'b0;
    rsp_d_n = 8'h00;
    rsp_e_n = 1'b0;
    unique case (st)
      S_IDLE: if (accept) begin
        st_n  = S_IDX_CTRL;
        start = 1'b1;
      end
      S_IDX_CTRL: if (done) begin
        st_n  = (op_q == OP_SRST) ? S_CTRL_WR : S_POLL;
        start = 1'b1;
      end
      S_POLL: if (done) begin
        if (op_q == OP_FLAGS) begin
          st_n    = S_RESP;
          rsp_d_n = {4'h0, rdata};
        end else if (poll_ok(op_q, pair_q, rdata)) begin
          st_n  = S_IDX_DATA;
          start = 1'b1;
        end else if (limit_hit) begin
          st_n    = S_RESP;
          rsp_e_n = 1'b1;
        end else if (POLL_GAP == 0) begin
          st_n  = S_POLL;
          start = 1'b1;
        end else begin
          st_n = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (gcnt == GLAST) begin
        st_n  = S_POLL;
        start = 1'b1;
      end
      S_IDX_DATA: if (done) begin
        st_n  = S_XFER_LO;
        start = 1'b1;
      end
      S_XFER_LO: if (done) begin
        st_n  = S_XFER_HI;
        start = 1'b1;
      end
      S_XFER_HI: if (done) begin
        st_n = S_RESP;
        if (op_q == OP_RECV)
          rsp_d_n = {rdata, lo_q};
      end
      S_CTRL_WR: if (done) st_n = S_RESP;
      S_RESP:    st_n = S_IDLE;
      default:   st_n = S_IDLE;
    endcase
  end

  // Access parameters belong to the state being entered
  always_comb begin
    is_read = 1'b0;
    a0      = 1'b0;
    wdata   = IDX_CTRL;
    unique case (st_n)
      S_POLL: begin
        is_read = 1'b1;
        a0      = 1'b1;
        wdata   = 4'h0;
      end
      S_IDX_DATA: wdata = pair_idx(pair_q);
      S_XFER_LO: begin
        is_read = (op_q == OP_RECV);
        a0      = 1'b1;
        wdata   = dat_q[3:0];
      end
      S_XFER_HI: begin
        is_read = (op_q == OP_RECV);
        a0      = 1'b1;
        wdata   = dat_q[7:4];
      end
      S_CTRL_WR: begin
        a0    = 1'b1;
        wdata = {3'b000, dat_q[0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge nIC) begin
    if (!nIC) begin
      st            <= S_IDLE;
      op_q          <= OP_SEND;
      pair_q        <= 1'b0;
      dat_q         <= 8'h00;
      lo_q          <= 4'h0;
      polls         <= 16'd0;
      gcnt          <= 8'd0;
      hst.cmd_ready <= 1'b0;
      hst.rsp_valid <= 1'b0;
      hst.rsp_data  <= 8'h00;
      hst.rsp_err   <= 1'b0;
    end else begin
      st            <= st_n;
      hst.cmd_ready <= (st_n == S_IDLE);
      hst.rsp_valid <= (st_n == S_RESP);
      if (st_n == S_RESP) begin
        hst.rsp_data <= rsp_d_n;
        hst.rsp_err  <= rsp_e_n;
      end
      if (accept) begin
        op_q   <= op_e'(hst.cmd_op);
        pair_q <= hst.cmd_pair;
        dat_q  <= hst.cmd_data;
      end
      if (st == S_XFER_LO && done)
        lo_q <= rdata;
      if (st == S_IDX_CTRL)
        polls <= 16'd0;
      else if (st == S_POLL && done)
        polls <= polls + 16'd1;
      gcnt <= (st == S_POLL_WAIT) ? gcnt + 8'd1 : 8'd0;
    end
  end

  pc060ha_bus_cycle #(
    .STROBE_CYC (STROBE_CYC)
  ) u_bus (
    .MCLK    (MCLK),
    .nIC     (nIC),
    .start   (start),
    .is_read (is_read),
    .a0      (a0),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .nMCS    (nMCS),
    .nMRD    (nMRD),
    .nMWR    (nMWR),
    .MA0     (MA0),
    .MD_OUT  (MD_OUT),
    .MD_OE   (MD_OE),
    .MD_IN   (MD_IN)
  );

endmodule
